// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one single-port synchronous memory between the instruction-fetch
//   read port (IF) and the load/store port (LS). At most one access is granted
//   per cycle, and a single outstanding read is tracked. Read data is routed
//   back to whichever requester owned the read, MEM_LAT cycles after the
//   access was issued. A requester that loses arbitration, or that finds the
//   memory busy, simply sees gnt=0 and stalls.
//
// Parameters:
//   MEM_LAT     memory read latency in cycles (1..4)
//   STARVE_MAX  consecutive IF losses before IF is forced to win (1..15)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN
//     defined   : contention between IF and LS alternates the winner; there
//                 is no starvation counter and STARVE_MAX has no effect.
//     undefined : LS has priority, backed by the IF starvation counter.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   if_req / if_addr             IF read request (held until granted)
//   if_gnt                       IF request accepted this cycle
//   if_rvalid / if_rdata         IF read response (one-cycle pulse)
//   ls_req / ls_we / ls_addr     LS request, direction and address
//   ls_wdata / ls_be             LS write data and byte enables
//   ls_gnt                       LS request accepted this cycle
//   ls_rvalid / ls_rdata         LS read response (one-cycle pulse)
//   mem_en / mem_we / mem_addr   memory access strobe, direction, address
//   mem_wdata / mem_be           memory write data and byte enables
//   mem_rdata                    memory read data (valid MEM_LAT after mem_en)
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
`endif

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_stateNext;
    logic [2:0]  r_latCnt;
    logic [2:0]  w_latCntNext;
    owner_t      r_owner;
    owner_t      w_ownerNext;
    logic [31:0] r_ifRdataHold;
    logic [31:0] w_ifRdataHoldNext;
    logic [31:0] r_lsRdataHold;
    logic [31:0] w_lsRdataHoldNext;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t      r_last;
    owner_t      w_lastNext;
`else
    logic [3:0]  r_starveCnt;
    logic [3:0]  w_starveCntNext;
`endif

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic        w_respCycle;
    logic        w_free;
    logic        w_contention;
    owner_t      w_winner;
    logic        w_grant;
    logic        w_ifGnt;
    logic        w_lsGnt;
    logic        w_lsWrite;
    logic        w_grantRead;
    logic        w_ifRvalid;
    logic        w_lsRvalid;

    // The memory can accept a new access when idle, or on the cycle the
    // pending read returns its data, which lets reads run back to back
    // at one per MEM_LAT cycles.
    always_comb begin
        w_respCycle  = 1'b0;
        w_free       = 1'b0;
        w_contention = 1'b0;
        w_respCycle  = (r_state == RD_WAIT) && (r_latCnt == 3'd1);
        w_free       = (r_state == IDLE) || w_respCycle;
        w_contention = if_req && ls_req;
    end

    // Winner selection. A lone requester always wins. Under contention the
    // selected policy decides: either strict alternation, or LS priority
    // that yields to IF once IF has lost STARVE_MAX times in a row.
    always_comb begin
        w_winner = OWNER_LS;
        if (w_contention) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = (r_last == OWNER_LS) ? OWNER_IF : OWNER_LS;
`else
            w_winner = (r_starveCnt == STARVE_LIM) ? OWNER_IF : OWNER_LS;
`endif
        end else if (if_req) begin
            w_winner = OWNER_IF;
        end
    end

    // Grant qualification. Nothing is granted during reset or while a read
    // is still in flight, so the pipeline sees those cycles as stalls.
    always_comb begin
        w_grant     = 1'b0;
        w_ifGnt     = 1'b0;
        w_lsGnt     = 1'b0;
        w_lsWrite   = 1'b0;
        w_grantRead = 1'b0;
        w_ifRvalid  = 1'b0;
        w_lsRvalid  = 1'b0;
        w_grant     = !rst && w_free && (if_req || ls_req);
        w_ifGnt     = w_grant && (w_winner == OWNER_IF);
        w_lsGnt     = w_grant && (w_winner == OWNER_LS);
        w_lsWrite   = w_lsGnt && ls_we;
        w_grantRead = w_ifGnt || (w_lsGnt && !ls_we);
        w_ifRvalid  = !rst && w_respCycle && (r_owner == OWNER_IF);
        w_lsRvalid  = !rst && w_respCycle && (r_owner == OWNER_LS);
    end

    // Next-state logic. A newly granted read always (re)loads the latency
    // counter, even on the response cycle of the previous read. A write
    // needs no tracking, so it falls through to IDLE unless a read is still
    // counting down.
    always_comb begin
        w_stateNext  = IDLE;
        w_latCntNext = 3'd0;
        w_ownerNext  = r_owner;
        if (w_grantRead) begin
            w_stateNext  = RD_WAIT;
            w_latCntNext = LAT_LOAD;
            w_ownerNext  = w_winner;
        end else if ((r_state == RD_WAIT) && !w_respCycle) begin
            w_stateNext  = RD_WAIT;
            w_latCntNext = r_latCnt - 3'd1;
        end
    end

    // Read-data hold registers. Each port keeps showing the last data it
    // received so that rdata stays stable while rvalid is low.
    always_comb begin
        w_ifRdataHoldNext = r_ifRdataHold;
        w_lsRdataHoldNext = r_lsRdataHold;
        if (w_ifRvalid) begin
            w_ifRdataHoldNext = mem_rdata;
        end
        if (w_lsRvalid) begin
            w_lsRdataHoldNext = mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who won the most recent contended cycle so the other side
    // wins the next one. Uncontended grants do not disturb the order.
    always_comb begin
        w_lastNext = r_last;
        if (w_grant && w_contention) begin
            w_lastNext = w_winner;
        end
    end
`else
    // Count how many times IF has been passed over for LS while the memory
    // was available. Any IF grant clears the count; it saturates at the
    // limit, where it forces the next contended grant to IF.
    always_comb begin
        w_starveCntNext = r_starveCnt;
        if (w_ifGnt) begin
            w_starveCntNext = 4'd0;
        end else if (if_req && w_lsGnt && (r_starveCnt != STARVE_LIM)) begin
            w_starveCntNext = r_starveCnt + 4'd1;
        end
    end
`endif

    // Sequential state. Reset returns to IDLE and discards any read in
    // flight, so its response is never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_latCnt      <= 3'd0;
            r_owner       <= OWNER_IF;
            r_ifRdataHold <= 32'd0;
            r_lsRdataHold <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last        <= OWNER_IF;
`else
            r_starveCnt   <= 4'd0;
`endif
        end else begin
            r_state       <= w_stateNext;
            r_latCnt      <= w_latCntNext;
            r_owner       <= w_ownerNext;
            r_ifRdataHold <= w_ifRdataHoldNext;
            r_lsRdataHold <= w_lsRdataHoldNext;
`ifdef ARB_ROUND_ROBIN_EN
            r_last        <= w_lastNext;
`else
            r_starveCnt   <= w_starveCntNext;
`endif
        end
    end

    // Output drive. The memory sees the winner's request; reads always use
    // full byte enables. Everything is forced low while reset is held.
    always_comb begin
        if_gnt    = w_ifGnt;
        ls_gnt    = w_lsGnt;
        if_rvalid = w_ifRvalid;
        ls_rvalid = w_lsRvalid;
        if_rdata  = 32'd0;
        ls_rdata  = 32'd0;
        mem_en    = w_grant;
        mem_we    = w_lsWrite;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        if (!rst) begin
            if_rdata = w_ifRvalid ? mem_rdata : r_ifRdataHold;
            ls_rdata = w_lsRvalid ? mem_rdata : r_lsRdataHold;
        end
        if (w_ifGnt) begin
            mem_addr = if_addr;
            mem_be   = 4'hF;
        end else if (w_lsGnt) begin
            mem_addr = ls_addr;
            mem_be   = ls_we ? ls_be : 4'hF;
            if (ls_we) begin
                mem_wdata = ls_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mem_port_arbiter with MEM_LAT=2 and STARVE_MAX=4.
// A small memory model returns addr ^ 32'hA5A5_0000 for every read, so the
// expected read data below is worked out by hand from each address.
// Inputs change 1 ns after each rising edge and outputs are sampled 1 ns
// later, well clear of the next edge.
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    int compareCount  = 0;
    int mismatchCount = 0;

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: a read issued in one cycle shows up MEM_LAT cycles later
    logic [31:0] memPipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        memPipe[0] <= (mem_en && !mem_we) ? (mem_addr ^ 32'hA5A5_0000) : 32'd0;
        for (int i = 1; i < MEM_LAT; i++) begin
            memPipe[i] <= memPipe[i-1];
        end
    end

    assign mem_rdata = memPipe[MEM_LAT-1];

    // Drive one cycle's worth of inputs just after the edge and let it settle
    task automatic applyStimulus(
        input logic        rstV,
        input logic        ifReqV,
        input logic [31:0] ifAddrV,
        input logic        lsReqV,
        input logic        lsWeV,
        input logic [31:0] lsAddrV,
        input logic [31:0] lsWdataV,
        input logic [3:0]  lsBeV
    );
        @(posedge clk);
        #1;
        rst      = rstV;
        if_req   = ifReqV;
        if_addr  = ifAddrV;
        ls_req   = lsReqV;
        ls_we    = lsWeV;
        ls_addr  = lsAddrV;
        ls_wdata = lsWdataV;
        ls_be    = lsBeV;
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    logic expIfWins;
    logic prevIfWon;
    int   starveModel;
    logic lastModelLs;

    // Directed scenario
    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_be = 4'd0;

        // Reset: requests present but every output must stay low
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h300, 32'd0, 4'd0);
        checkOutput("rstIfGnt",  32'(if_gnt), 32'd0);
        checkOutput("rstLsGnt",  32'(ls_gnt), 32'd0);
        checkOutput("rstMemEn",  32'(mem_en), 32'd0);
        checkOutput("rstMemAddr", mem_addr,   32'd0);
        checkOutput("rstMemBe",  32'(mem_be), 32'd0);

        // IF-only read, then a back-to-back read on the response cycle
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t1IfGnt",   32'(if_gnt), 32'd1);
        checkOutput("t1MemEn",   32'(mem_en), 32'd1);
        checkOutput("t1MemAddr", mem_addr,    32'h10);
        checkOutput("t1MemWe",   32'(mem_we), 32'd0);
        checkOutput("t1MemBe",   32'(mem_be), 32'hF);
        applyStimulus(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t1BusyGnt", 32'(if_gnt), 32'd0);
        checkOutput("t1BusyEn",  32'(mem_en), 32'd0);
        checkOutput("t1EarlyRv", 32'(if_rvalid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t1Rvalid",  32'(if_rvalid), 32'd1);
        checkOutput("t1Rdata",   if_rdata,       32'hA5A5_0010);
        checkOutput("t1B2bGnt",  32'(if_gnt),    32'd1);
        checkOutput("t1B2bAddr", mem_addr,       32'h14);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t1RvLow",   32'(if_rvalid), 32'd0);
        checkOutput("t1Hold",    if_rdata,       32'hA5A5_0010);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t1Rvalid2", 32'(if_rvalid), 32'd1);
        checkOutput("t1Rdata2",  if_rdata,       32'hA5A5_0014);

        // Contention with an LS write: LS wins, IF follows next cycle
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h200, 32'hCAFE_1234, 4'b0011);
        checkOutput("t2LsGnt",   32'(ls_gnt),  32'd1);
        checkOutput("t2IfGnt",   32'(if_gnt),  32'd0);
        checkOutput("t2MemWe",   32'(mem_we),  32'd1);
        checkOutput("t2MemBe",   32'(mem_be),  32'h3);
        checkOutput("t2MemAddr", mem_addr,     32'h200);
        checkOutput("t2MemWdat", mem_wdata,    32'hCAFE_1234);
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t2IfNext",  32'(if_gnt),  32'd1);
        checkOutput("t2IfAddr",  mem_addr,     32'h20);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t2Rvalid",  32'(if_rvalid), 32'd1);
        checkOutput("t2Rdata",   if_rdata,       32'hA5A5_0020);
        checkOutput("t2LsRvLow", 32'(ls_rvalid), 32'd0);

        // Reset pulsed while an IF read is in flight: its response is lost
        applyStimulus(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t4IfGnt",   32'(if_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t4RstEn",   32'(mem_en),    32'd0);
        checkOutput("t4RstRv",   32'(if_rvalid), 32'd0);
        checkOutput("t4RstData", if_rdata,       32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t4Dropped", 32'(if_rvalid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h34, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t4NewGnt",  32'(if_gnt), 32'd1);
        checkOutput("t4HoldClr", if_rdata,    32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t4Rvalid",  32'(if_rvalid), 32'd1);
        checkOutput("t4Rdata",   if_rdata,       32'hA5A5_0034);

        // LS read, then an LS write granted on that read's response cycle
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 4'd0);
        checkOutput("t6LsGnt",   32'(ls_gnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h404, 32'h1234_5678, 4'hF);
        checkOutput("t6Stall",   32'(ls_gnt), 32'd0);
        checkOutput("t6StallEn", 32'(mem_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h404, 32'h1234_5678, 4'hF);
        checkOutput("t6Rvalid",  32'(ls_rvalid), 32'd1);
        checkOutput("t6Rdata",   ls_rdata,       32'hA5A5_0400);
        checkOutput("t6WrGnt",   32'(ls_gnt),    32'd1);
        checkOutput("t6WrWe",    32'(mem_we),    32'd1);
        checkOutput("t6WrAddr",  mem_addr,       32'h404);
        applyStimulus(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("t6IdleGnt", 32'(if_gnt),    32'd1);
        checkOutput("t6RvLow",   32'(ls_rvalid), 32'd0);
        checkOutput("t6LsHold",  ls_rdata,       32'hA5A5_0400);

        // Fresh reset, then both ports issue reads continuously
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        starveModel = 0;
        lastModelLs = 1'b0;
        prevIfWon   = 1'b0;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            expIfWins   = lastModelLs;
            lastModelLs = !expIfWins;
`else
            expIfWins = (starveModel == STARVE_MAX);
            if (expIfWins) begin
                starveModel = 0;
            end else if (starveModel < STARVE_MAX) begin
                starveModel++;
            end
`endif
            applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'd0, 4'd0);
            checkOutput($sformatf("arbIfGnt%0d", k), 32'(if_gnt), 32'(expIfWins));
            checkOutput($sformatf("arbLsGnt%0d", k), 32'(ls_gnt), 32'(!expIfWins));
            if (k > 0) begin
                checkOutput($sformatf("arbIfRv%0d", k), 32'(if_rvalid), 32'(prevIfWon));
                checkOutput($sformatf("arbLsRv%0d", k), 32'(ls_rvalid), 32'(!prevIfWon));
                if (prevIfWon) begin
                    checkOutput($sformatf("arbIfRd%0d", k), if_rdata, 32'hA5A5_0040);
                end else begin
                    checkOutput($sformatf("arbLsRd%0d", k), ls_rdata, 32'hA5A5_0300);
                end
            end
            prevIfWon = expIfWins;
            applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'd0, 4'd0);
            checkOutput($sformatf("arbBusy%0d", k), 32'({if_gnt, ls_gnt}), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("arbLastIfRv", 32'(if_rvalid), 32'(prevIfWon));
        checkOutput("arbLastLsRv", 32'(ls_rvalid), 32'(!prevIfWon));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
